paddle_engine: RTL and testbench

//  Generalised two-paddle controller for the OLED game screens.
//  - Left paddle: driven by up/down buttons, with press-step and hold-to-auto-repeat.
//  - Right paddle: slew-limited follower of the audio volume level.

---
 rtl/paddle_pkg.sv | 55 +++++
 rtl/paddle_hold_fsm.sv | 61 ++++++
 rtl/paddle_engine.sv | 91 +++++++++
 tb/tb_paddle_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared constants, state enum and coordinate helpers for the two-paddle engine.
package paddle_pkg;

   localparam int unsigned DISP_W    = 96;
   localparam int unsigned DISP_H    = 64;
   localparam int unsigned PAD_H     = 20;
   localparam int unsigned PAD_W     = 3;
   localparam int unsigned BORDER    = 3;
   localparam int unsigned BTN_STEP  = 6;
   localparam int unsigned LVL_STEP  = 3;
   localparam int unsigned SLEW_MAX  = 2;
   localparam int unsigned REP_DELAY = 8;
   localparam int unsigned REP_RATE  = 2;
   localparam int unsigned LVL_W     = 4;
   localparam int unsigned COORD_W   = 7;
   localparam int unsigned CNT_W     = $clog2(REP_DELAY + 1);

   localparam int unsigned HALF_W   = PAD_W / 2;
   localparam int unsigned HALF_H   = PAD_H / 2;
   localparam int unsigned Y_MIN    = PAD_H / 2;
   localparam int unsigned Y_MAX    = DISP_H - 1 - PAD_H / 2;
   localparam int unsigned Y_MID    = DISP_H / 2;
   localparam int unsigned X_USER   = BORDER;
   localparam int unsigned X_AUDIO  = DISP_W - 1 - BORDER;
   localparam int unsigned LVL_BASE = DISP_H - PAD_H / 2;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic signed [7:0]  sval_t;

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} hold_state_t;

   function automatic sval_t to_s(input coord_t c);
      return signed'({1'b0, c});
   endfunction

   function automatic sval_t const_s(input int unsigned v);
      return signed'(8'(v));
   endfunction

   // Signed intermediates keep a step past either edge from wrapping.
   function automatic coord_t clamp_y(input sval_t v);
      coord_t r;
      if (v < const_s(Y_MIN))      r = COORD_W'(Y_MIN);
      else if (v > const_s(Y_MAX)) r = COORD_W'(Y_MAX);
      else                         r = COORD_W'(v);
      return r;
   endfunction

   function automatic logic near(input coord_t a, input coord_t c, input int unsigned half);
      sval_t d;
      d = to_s(a) - to_s(c);
      return (d <= const_s(half)) && (d >= -const_s(half));
   endfunction

endpackage

// File: rtl/paddle_hold_fsm.sv
// Button press-step / hold-to-repeat FSM; step pulses are valid in the tick cycle.
module paddle_hold_fsm
   import paddle_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic enable,
   input  logic btn_up,
   input  logic btn_dn,
   output logic step_up_c,
   output logic step_dn_c
);

   hold_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] limit;
   logic             dir_up;
   logic             press;
   logic             turn;
   logic             expire;
   logic             step;

   // Up wins when both buttons are held; a direction flip restarts the hold.
   always_comb begin
      press     = btn_up | btn_dn;
      cnt_inc   = cnt + CNT_W'(1);
      limit     = (state == REPEAT) ? CNT_W'(REP_RATE) : CNT_W'(REP_DELAY);
      turn      = press && (btn_up != dir_up);
      expire    = (cnt_inc == limit);
      step      = 1'b0;
      if (tick && enable && press)
         step = (state == IDLE) || turn || expire;
      step_up_c = step && btn_up;
      step_dn_c = step && !btn_up;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         dir_up <= 1'b0;
      end else if (tick) begin
         if (!enable || !press) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (state == IDLE || turn) begin
            state  <= HOLD;
            cnt    <= '0;
            dir_up <= btn_up;
         end else if (expire) begin
            state <= REPEAT;
            cnt   <= '0;
         end else begin
            cnt <= cnt_inc;
         end
      end
   end

endmodule

// File: rtl/paddle_engine.sv
// Two-paddle controller: button-driven left paddle, slew-limited right paddle, registered hit test.
// Define PADDLE_AI_EN to make the right paddle track ballY instead of the audio level.
module paddle_engine
   import paddle_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               enable,
   input  logic               btnU,
   input  logic               btnD,
   input  logic [LVL_W-1:0]   level,
   input  logic [COORD_W-1:0] ballY,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [COORD_W-1:0] userX,
   output logic [COORD_W-1:0] userY,
   output logic [COORD_W-1:0] audioX,
   output logic [COORD_W-1:0] audioY,
   output logic               userHit,
   output logic               audioHit
);

   logic   step_up_c;
   logic   step_dn_c;
   coord_t user_next_c;
   coord_t audio_target_c;
   coord_t audio_next_c;
   sval_t  diff_c;
   sval_t  slew_c;

   paddle_hold_fsm u_hold (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .enable    (enable),
      .btn_up    (btnU),
      .btn_dn    (btnD),
      .step_up_c (step_up_c),
      .step_dn_c (step_dn_c)
   );

   always_comb begin
      user_next_c = userY;
      if (step_up_c)      user_next_c = clamp_y(to_s(userY) - const_s(BTN_STEP));
      else if (step_dn_c) user_next_c = clamp_y(to_s(userY) + const_s(BTN_STEP));
   end

`ifdef PADDLE_AI_EN
   logic [LVL_W-1:0] unused_level;
   assign unused_level   = level;
   assign audio_target_c = clamp_y(to_s(ballY));
`else
   logic [COORD_W-1:0] unused_ball;
   assign unused_ball    = ballY;
   assign audio_target_c = clamp_y(const_s(LVL_BASE) - const_s(LVL_STEP) * signed'(8'(level)));
`endif

   // Move toward the target by at most SLEW_MAX per tick.
   always_comb begin
      diff_c = to_s(audio_target_c) - to_s(audioY);
      if (diff_c > const_s(SLEW_MAX))       slew_c = const_s(SLEW_MAX);
      else if (diff_c < -const_s(SLEW_MAX)) slew_c = -const_s(SLEW_MAX);
      else                                  slew_c = diff_c;
      audio_next_c = COORD_W'(to_s(audioY) + slew_c);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         userX    <= COORD_W'(X_USER);
         audioX   <= COORD_W'(X_AUDIO);
         userY    <= COORD_W'(Y_MID);
         audioY   <= COORD_W'(Y_MID);
         userHit  <= 1'b0;
         audioHit <= 1'b0;
      end else begin
         userHit  <= enable && near(x, userX, HALF_W) && near(y, userY, HALF_H);
         audioHit <= enable && near(x, audioX, HALF_W) && near(y, audioY, HALF_H);
         if (tick) begin
            if (!enable) begin
               userY  <= COORD_W'(Y_MID);
               audioY <= COORD_W'(Y_MID);
            end else begin
               userY  <= user_next_c;
               audioY <= audio_next_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_paddle_engine.sv
// Randomized scoreboard bench for paddle_engine against a rule-level reference model.
module tb_paddle_engine;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       tick   = 1'b0;
   logic       enable = 1'b1;
   logic       btnU   = 1'b0;
   logic       btnD   = 1'b0;
   logic [3:0] level  = 4'd0;
   logic [6:0] ballY  = 7'd32;
   logic [6:0] x      = 7'd0;
   logic [6:0] y      = 7'd0;
   logic [6:0] userX, userY, audioX, audioY;
   logic       userHit, audioHit;

   paddle_engine dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .enable   (enable),
      .btnU     (btnU),
      .btnD     (btnD),
      .level    (level),
      .ballY    (ballY),
      .x        (x),
      .y        (y),
      .userX    (userX),
      .userY    (userY),
      .audioX   (audioX),
      .audioY   (audioY),
      .userHit  (userHit),
      .audioHit (audioHit)
   );

   always #5 clk = ~clk;

   typedef struct {
      int uy;
      int ay;
      int ux;
      int ax;
      int uh;
      int ah;
   } exp_t;

   exp_t sb[$];

   // Reference model state: centres, held direction (0 none, 1 up, 2 down), ticks held.
   int m_uy = 32, m_ay = 32, m_held = 0, m_k = 0;
   int n_pass = 0, n_total = 0;

   // Values applied at the next negedge.
   bit       nxt_u = 0, nxt_d = 0, nxt_en = 1;
   int       nxt_lv = 0, nxt_ball = 32;

   function automatic int clampy(input int v);
      return (v < 10) ? 10 : ((v > 53) ? 53 : v);
   endfunction

   function automatic int absi(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int in_pad(input int px, input int py, input int cx, input int cy);
      return (absi(px - cx) <= 1 && absi(py - cy) <= 10) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_push();
      exp_t e;
      int dir, tgt, d;
      e.uh = (!rst && enable) ? in_pad(int'(x), int'(y), 3, m_uy) : 0;
      e.ah = (!rst && enable) ? in_pad(int'(x), int'(y), 92, m_ay) : 0;
      if (rst) begin
         m_uy = 32; m_ay = 32; m_held = 0; m_k = 0;
      end else if (tick) begin
         if (!enable) begin
            m_uy = 32; m_ay = 32; m_held = 0; m_k = 0;
         end else begin
            dir = btnU ? 1 : (btnD ? 2 : 0);
            if (dir == 0) begin
               m_held = 0; m_k = 0;
            end else begin
               if (dir != m_held) begin
                  m_held = dir; m_k = 1;
               end else begin
                  m_k++;
               end
               // First tick steps; after REP_DELAY more held ticks, every REP_RATE ticks.
               if (m_k == 1 || (m_k - 1 >= 8 && (m_k - 9) % 2 == 0))
                  m_uy = (dir == 1) ? clampy(m_uy - 6) : clampy(m_uy + 6);
            end
`ifdef PADDLE_AI_EN
            tgt = clampy(int'(ballY));
`else
            tgt = clampy(54 - 3 * int'(level));
`endif
            d = tgt - m_ay;
            if (d > 2) d = 2;
            if (d < -2) d = -2;
            m_ay = m_ay + d;
         end
      end
      e.uy = m_uy; e.ay = m_ay; e.ux = 3; e.ax = 92;
      sb.push_back(e);
   endtask

   task automatic cyc(input bit r, input bit t);
      @(negedge clk);
      rst    = r;
      tick   = t;
      btnU   = nxt_u;
      btnD   = nxt_d;
      enable = nxt_en;
      level  = 4'(nxt_lv);
      ballY  = 7'(nxt_ball);
      x = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 5)) : 7'($urandom_range(90, 94));
      y = 7'($urandom_range(0, 63));
      model_push();
   endtask

   task automatic hit_at(input int px, input int py);
      @(negedge clk);
      rst = 1'b0; tick = 1'b0;
      x = 7'(px); y = 7'(py);
      model_push();
   endtask

   task automatic held_ticks(input int n);
      repeat (n) begin
         cyc(0, 1);
         cyc(0, 0);
      end
   endtask

   // Async reset lands mid-cycle; outputs must clear before the next edge.
   task automatic rst_pulse();
      cyc(1, 1);
      #2;
      chk("async_userY", int'(userY), 32);
      chk("async_audioY", int'(audioY), 32);
      chk("async_userX", int'(userX), 3);
      chk("async_audioX", int'(audioX), 92);
      chk("async_userHit", int'(userHit), 0);
      chk("async_audioHit", int'(audioHit), 0);
      cyc(0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("userY", int'(userY), e.uy);
            chk("audioY", int'(audioY), e.ay);
            chk("userX", int'(userX), e.ux);
            chk("audioX", int'(audioX), e.ax);
            chk("userHit", int'(userHit), e.uh);
            chk("audioHit", int'(audioHit), e.ah);
         end
      end
   end

   initial begin : driver
      cyc(1, 0);
      cyc(1, 1);
      cyc(0, 0);

      // Up held from centre: step, hold delay, repeat, saturate at the top.
      nxt_u = 1;
      held_ticks(20);
      nxt_u = 0;
      cyc(0, 1);

      // Down held to the bottom clamp, then both buttons (up wins).
      nxt_en = 0; cyc(0, 1); nxt_en = 1;
      nxt_d = 1;
      held_ticks(14);
      nxt_u = 1;
      held_ticks(6);
      nxt_u = 0;
      held_ticks(3);
      nxt_u = 1; nxt_d = 0;
      held_ticks(3);
      nxt_u = 0;
      cyc(0, 1);

      // Audio level step 0 -> 15.
      nxt_lv = 0;
      repeat (15) cyc(0, 1);
      nxt_lv = 15;
      repeat (30) cyc(0, 1);

      // Pixel hit points around the recentred left paddle.
      nxt_en = 0; cyc(0, 1); nxt_en = 1;
      cyc(0, 0);
      hit_at(3, 22);
      hit_at(3, 43);
      hit_at(5, 32);
      hit_at(4, 42);
      hit_at(92, 42);
      hit_at(91, 21);
      cyc(0, 0);

      // Ball far down; only affects the right paddle in the AI build.
      nxt_ball = 60;
      repeat (20) begin
         nxt_lv = $urandom_range(0, 15);
         cyc(0, 1);
      end

      // Reset mid-motion.
      nxt_u = 1;
      held_ticks(5);
      rst_pulse();
      nxt_u = 0;

      repeat (900) begin
         if ($urandom_range(0, 7) == 0) begin
            nxt_u = 1'($urandom_range(0, 1));
            nxt_d = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 9) == 0) nxt_lv = $urandom_range(0, 15);
         if ($urandom_range(0, 9) == 0) nxt_ball = $urandom_range(0, 127);
         nxt_en = ($urandom_range(0, 59) != 0);
         cyc(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
